// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with a valid/ready load/store front end.
// Handles B/H/W accesses, sign/zero extension and word-crossing splits.
module data_mem_lsu #(
   parameter int DEPTH          = 1024,
   parameter int ADDR_W         = 32,
   parameter int ALLOW_MISALIGN = 1,
   parameter int DBG_EN         = 1
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [31:0]       dbg_data_o
);

   // state   | meaning
   // IDLE    | ready; accepts a request, serves single-word access or beat 1
   // SPLIT   | not ready; beat 2 of a word-crossing access on the next word

   localparam int AW = $clog2(DEPTH);
   localparam int NW = DEPTH / 4;
   localparam int IW = AW - 2;

   typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

   logic [31:0]   mem_q [NW];
   state_t        state_q;
   logic          ready_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic [31:0]   rsp_rdata_q;
   logic [IW-1:0] idx_q;
   logic [1:0]    off_q;
   logic [2:0]    f3_q;
   logic          we_q;
   logic [31:0]   lo_q;
   logic [31:0]   hi_data_q;
   logic [3:0]    hi_be_q;

   logic [2:0]        size_c;
   logic              f3_bad_c;
   logic [ADDR_W:0]   last_addr_c;
   logic              rng_err_c;
   logic              mis_c;
   logic              acc_err_c;
   logic              cross_c;
   logic [1:0]        off_c;
   logic [IW-1:0]     idx_c;
   logic [7:0]        mask_c;
   logic [63:0]       st_data_c;
   logic [7:0]        st_be_c;
   logic [31:0]       rd_lo_c;
   logic [31:0]       rd_hi_c;
   logic [31:0]       ld_raw_c;
   logic [31:0]       sp_raw_c;
   logic              acc_c;
   logic              wr_en_c;
   logic [IW-1:0]     wr_idx_c;
   logic [31:0]       wr_data_c;
   logic [3:0]        wr_be_c;
   logic              dbg_oob_c;
   logic              unused_dbg;

   function automatic logic [31:0] ext_f(input logic [31:0] raw, input logic [2:0] f3);
      case (f3)
         3'b000:  ext_f = {{24{raw[7]}}, raw[7:0]};
         3'b001:  ext_f = {{16{raw[15]}}, raw[15:0]};
         3'b100:  ext_f = {24'd0, raw[7:0]};
         3'b101:  ext_f = {16'd0, raw[15:0]};
         default: ext_f = raw;
      endcase
   endfunction

   always_comb begin
      size_c   = 3'd1;
      f3_bad_c = 1'b0;
      case (req_funct3_i)
         3'b000, 3'b100: size_c = 3'd1;
         3'b001, 3'b101: size_c = 3'd2;
         3'b010:         size_c = 3'd4;
         default:        f3_bad_c = 1'b1;
      endcase
      if (req_we_i && req_funct3_i[2]) f3_bad_c = 1'b1;
   end

   assign off_c       = req_addr_i[1:0];
   assign idx_c       = req_addr_i[AW-1:2];
   // The last byte bound also catches any nonzero address bit above the array.
   assign last_addr_c = {1'b0, req_addr_i} + (ADDR_W+1)'(size_c - 3'd1);
   assign rng_err_c   = last_addr_c >= (ADDR_W+1)'(DEPTH);
   assign mis_c       = ((size_c == 3'd2) && off_c[0]) || ((size_c == 3'd4) && (off_c != 2'd0));
   assign acc_err_c   = f3_bad_c || rng_err_c || (mis_c && (ALLOW_MISALIGN == 0));
   assign cross_c     = ({1'b0, off_c} + size_c) > 3'd4;
   assign acc_c       = req_valid_i && ready_q;

   assign mask_c    = (size_c == 3'd1) ? 8'h01 : (size_c == 3'd2) ? 8'h03 : 8'h0F;
   assign st_data_c = {32'd0, req_wdata_i} << {off_c, 3'b000};
   assign st_be_c   = mask_c << off_c;

   assign rd_lo_c  = mem_q[idx_c];
   assign rd_hi_c  = mem_q[idx_q];
   assign ld_raw_c = rd_lo_c >> {off_c, 3'b000};
   assign sp_raw_c = 32'({rd_hi_c, lo_q} >> {off_q, 3'b000});

   always_comb begin
      wr_en_c   = 1'b0;
      wr_idx_c  = idx_c;
      wr_data_c = st_data_c[31:0];
      wr_be_c   = st_be_c[3:0];
      if (state_q == ST_SPLIT) begin
         wr_en_c   = we_q;
         wr_idx_c  = idx_q;
         wr_data_c = hi_data_q;
         wr_be_c   = hi_be_q;
      end else if (acc_c && req_we_i && !acc_err_c) begin
         wr_en_c = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NW; i++) mem_q[i] <= '0;
      end else if (wr_en_c) begin
         for (int b = 0; b < 4; b++)
            if (wr_be_c[b]) mem_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         idx_q       <= '0;
         off_q       <= '0;
         f3_q        <= '0;
         we_q        <= 1'b0;
         lo_q        <= '0;
         hi_data_q   <= '0;
         hi_be_q     <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (acc_c) begin
                  if (acc_err_c) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (cross_c) begin
                     state_q   <= ST_SPLIT;
                     ready_q   <= 1'b0;
                     idx_q     <= idx_c + 1'b1;
                     off_q     <= off_c;
                     f3_q      <= req_funct3_i;
                     we_q      <= req_we_i;
                     lo_q      <= rd_lo_c;
                     hi_data_q <= st_data_c[63:32];
                     hi_be_q   <= st_be_c[7:4];
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_rdata_q <= req_we_i ? 32'd0 : ext_f(ld_raw_c, req_funct3_i);
                  end
               end
            end
            ST_SPLIT: begin
               state_q     <= ST_IDLE;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= we_q ? 32'd0 : ext_f(sp_raw_c, f3_q);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

   assign dbg_oob_c  = (dbg_addr_i >> AW) != '0;
   assign dbg_data_o = ((DBG_EN != 0) && !dbg_oob_c) ? mem_q[dbg_addr_i[AW-1:2]] : 32'd0;
   assign unused_dbg = ^dbg_addr_i[1:0];

endmodule
